// File: rtl/alu8_pkg.sv
// Shared opcode encoding and uio pin bit positions for the 8-bit ALU.
package alu8_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;

    localparam int unsigned OP_LSB = 0;
    localparam int unsigned OP_MSB = 3;
    localparam int unsigned LD_A   = 4;
    localparam int unsigned LD_B   = 5;
    localparam int unsigned FLAG_Z = 6;
    localparam int unsigned FLAG_C = 7;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ASR  = 4'h8,
        OP_ROL  = 4'h9,
        OP_ROR  = 4'hA,
        OP_INC  = 4'hB,
        OP_DEC  = 4'hC,
        OP_ADC  = 4'hD,
        OP_MUL  = 4'hE,
        OP_PASS = 4'hF
    } alu_op_e;

endpackage

// File: rtl/alu8_core.sv
// Combinational ALU datapath: result, carry/borrow and zero for one opcode.
module alu8_core
    import alu8_pkg::*;
(
    input  alu_op_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                cin,
    output logic [DATA_W-1:0]   y,
    output logic                cout,
    output logic                zero
);

    logic [DATA_W:0]     sum9;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        y    = '0;
        cout = 1'b0;
        sum9 = '0;
        prod = '0;
        case (op)
            OP_ADD: begin
                sum9 = {1'b0, a} + {1'b0, b};
                y    = sum9[DATA_W-1:0];
                cout = sum9[DATA_W];
            end
            // Ninth bit of the 9-bit difference is set exactly when a < b.
            OP_SUB: begin
                sum9 = {1'b0, a} - {1'b0, b};
                y    = sum9[DATA_W-1:0];
                cout = sum9[DATA_W];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y    = {a[DATA_W-2:0], 1'b0};
                cout = a[DATA_W-1];
            end
            OP_SHR: begin
                y    = {1'b0, a[DATA_W-1:1]};
                cout = a[0];
            end
            OP_ASR: begin
                y    = {a[DATA_W-1], a[DATA_W-1:1]};
                cout = a[0];
            end
            OP_ROL: begin
                y    = {a[DATA_W-2:0], a[DATA_W-1]};
                cout = a[DATA_W-1];
            end
            OP_ROR: begin
                y    = {a[0], a[DATA_W-1:1]};
                cout = a[0];
            end
            OP_INC: begin
                sum9 = {1'b0, a} + (DATA_W+1)'(1);
                y    = sum9[DATA_W-1:0];
                cout = sum9[DATA_W];
            end
            OP_DEC: begin
                sum9 = {1'b0, a} - (DATA_W+1)'(1);
                y    = sum9[DATA_W-1:0];
                cout = sum9[DATA_W];
            end
            OP_ADC: begin
                sum9 = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(cin);
                y    = sum9[DATA_W-1:0];
                cout = sum9[DATA_W];
            end
            OP_MUL: begin
                prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
                y    = prod[DATA_W-1:0];
                cout = |prod[2*DATA_W-1:DATA_W];
            end
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/tt_um_alu8bit_kdcastillor.sv
// Tiny Tapeout wrapper: operand/result/flag registers around alu8_core.
module tt_um_alu8bit_kdcastillor
    import alu8_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] y_q;
    logic              c_q;
    logic              z_q;

    alu_op_e           op_c;
    logic [DATA_W-1:0] y_c;
    logic              cout_c;
    logic              zero_c;
    logic              unused_uio_c;

    assign op_c         = alu_op_e'(uio_in[OP_MSB:OP_LSB]);
    assign unused_uio_c = &{1'b0, uio_in[7:6]};

    alu8_core u_core (
        .op   (op_c),
        .a    (a_q),
        .b    (b_q),
        .cin  (c_q),
        .y    (y_c),
        .cout (cout_c),
        .zero (zero_c)
    );

    // Loads and result share the edge; the core sees the pre-edge operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            y_q <= '0;
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else if (ena) begin
            if (uio_in[LD_A]) a_q <= ui_in;
            if (uio_in[LD_B]) b_q <= ui_in;
            y_q <= y_c;
            c_q <= cout_c;
            z_q <= zero_c;
        end
    end

    assign uo_out  = y_q;
    assign uio_out = {c_q, z_q, 6'b0};
    assign uio_oe  = 8'hC0;

endmodule

// File: tb/tb_tt_um_alu8bit_kdcastillor.sv
// Directed-vector bench with an arithmetic reference model checked every cycle.
module tb_tt_um_alu8bit_kdcastillor;

    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h0F;
    logic       ena    = 1'b1;
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int ma = 0, mb = 0, my = 0, mc = 0, mz = 0;

    tt_um_alu8bit_kdcastillor dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    // Reference ALU in plain integer arithmetic.
    function automatic void ref_alu(input int op, input int a, input int b, input int ci,
                                    output int y, output int co);
        int r;
        r  = 0;
        co = 0;
        case (op)
            0:  begin r = a + b;       co = (r > 255) ? 1 : 0; end
            1:  begin r = a - b + 256; co = (a < b) ? 1 : 0;   end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 255 - a;
            6:  begin r = a * 2;                    co = a / 128; end
            7:  begin r = a / 2;                    co = a % 2;   end
            8:  begin r = a / 2 + (a / 128) * 128;  co = a % 2;   end
            9:  begin r = a * 2 + a / 128;          co = a / 128; end
            10: begin r = a / 2 + (a % 2) * 128;    co = a % 2;   end
            11: begin r = a + 1;   co = (a == 255) ? 1 : 0; end
            12: begin r = a + 255; co = (a == 0) ? 1 : 0;   end
            13: begin r = a + b + ci; co = (r > 255) ? 1 : 0; end
            14: begin r = a * b;      co = (r > 255) ? 1 : 0; end
            default: r = a;
        endcase
        y = r % 256;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int ny, nc;
        if (!rst_n) begin
            ma = 0; mb = 0; my = 0; mc = 0; mz = 0;
        end else if (ena) begin
            ref_alu(int'(uio_in[3:0]), ma, mb, mc, ny, nc);
            if (uio_in[4]) ma = int'(ui_in);
            if (uio_in[5]) mb = int'(ui_in);
            my = ny;
            mc = nc;
            mz = (ny == 0) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (uo_out !== 8'(my)) begin
                n_err++;
                $display("FAIL model_y t=%0t: got %02h expected %02h", $time, uo_out, 8'(my));
            end
            n_vec++;
            if (uio_out !== 8'(mc * 128 + mz * 64)) begin
                n_err++;
                $display("FAIL model_flags t=%0t: got %02h expected %02h", $time, uio_out,
                         8'(mc * 128 + mz * 64));
            end
            n_vec++;
            if (uio_oe !== 8'hC0) begin
                n_err++;
                $display("FAIL uio_oe t=%0t: got %02h expected c0", $time, uio_oe);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] op, input logic la, input logic lb, input logic [7:0] d);
        uio_in = {2'b10, lb, la, op};
        ui_in  = d;
        @(posedge clk);
        #2;
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        step(4'hF, 1'b1, 1'b0, a);
        step(4'hF, 1'b0, 1'b1, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pairs_a [4];
        logic [7:0] pairs_b [4];
        pairs_a = '{8'h00, 8'hFF, 8'h5A, 8'h80};
        pairs_b = '{8'hFF, 8'h01, 8'hA5, 8'h7F};

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) step(4'hF, 1'b0, 1'b0, 8'h00);
        check("rst_y", uo_out, 8'h00);
        check("rst_flags", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'hC0);
        rst_n = 1'b1;
        step(4'hF, 1'b0, 1'b0, 8'h00);
        check("post_rst_y", uo_out, 8'h00);
        check("post_rst_flags", uio_out, 8'h40);

        load_ab(8'hC8, 8'h64);
        step(4'h0, 1'b0, 1'b0, 8'h00);
        check("add_y", uo_out, 8'h2C);
        check("add_flags", uio_out, 8'h80);
        step(4'hD, 1'b0, 1'b0, 8'h00);
        check("adc_y", uo_out, 8'h2D);
        check("adc_flags", uio_out, 8'h80);

        load_ab(8'h05, 8'h05);
        step(4'h1, 1'b0, 1'b0, 8'h00);
        check("sub_eq_y", uo_out, 8'h00);
        check("sub_eq_flags", uio_out, 8'h40);
        step(4'hF, 1'b1, 1'b0, 8'h03);
        step(4'h1, 1'b0, 1'b0, 8'h00);
        check("sub_borrow_y", uo_out, 8'hFE);
        check("sub_borrow_flags", uio_out, 8'h80);

        step(4'hF, 1'b1, 1'b0, 8'h81);
        step(4'h6, 1'b0, 1'b0, 8'h00);
        check("shl_y", uo_out, 8'h02);
        check("shl_flags", uio_out, 8'h80);
        step(4'h7, 1'b0, 1'b0, 8'h00);
        check("shr_y", uo_out, 8'h40);
        step(4'h8, 1'b0, 1'b0, 8'h00);
        check("asr_y", uo_out, 8'hC0);
        step(4'h9, 1'b0, 1'b0, 8'h00);
        check("rol_y", uo_out, 8'h03);
        step(4'hA, 1'b0, 1'b0, 8'h00);
        check("ror_y", uo_out, 8'hC0);
        check("ror_flags", uio_out, 8'h80);

        // Loading A while computing: result must still use the old A (81).
        step(4'hF, 1'b1, 1'b0, 8'hFF);
        check("load_overlap_y", uo_out, 8'h81);
        step(4'hB, 1'b0, 1'b0, 8'h00);
        check("inc_wrap_y", uo_out, 8'h00);
        check("inc_wrap_flags", uio_out, 8'hC0);
        step(4'hF, 1'b1, 1'b0, 8'h00);
        step(4'hC, 1'b0, 1'b0, 8'h00);
        check("dec_wrap_y", uo_out, 8'hFF);
        check("dec_wrap_flags", uio_out, 8'h80);

        load_ab(8'h10, 8'h10);
        step(4'hE, 1'b0, 1'b0, 8'h00);
        check("mul_hi_y", uo_out, 8'h00);
        check("mul_hi_flags", uio_out, 8'hC0);
        step(4'hF, 1'b1, 1'b1, 8'h0F);
        step(4'hE, 1'b0, 1'b0, 8'h00);
        check("mul_lo_y", uo_out, 8'hE1);
        check("mul_lo_flags", uio_out, 8'h00);

        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(4'(i * 3), 1'b1, 1'b1, 8'(8'h33 + i));
            check("ena_hold_y", uo_out, 8'hE1);
            check("ena_hold_flags", uio_out, 8'h00);
        end
        ena = 1'b1;
        step(4'hF, 1'b0, 1'b0, 8'h00);
        check("ena_noload_y", uo_out, 8'h0F);

        for (int p = 0; p < 4; p++) begin
            load_ab(pairs_a[p], pairs_b[p]);
            for (int op = 0; op < 16; op++) step(4'(op), 1'b0, 1'b0, 8'h00);
        end

        load_ab(8'h7E, 8'h42);
        step(4'h0, 1'b0, 1'b0, 8'h00);
        check("pre_async_y", uo_out, 8'hC0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_y", uo_out, 8'h00);
        check("async_rst_flags", uio_out, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(4'h0, 1'b0, 1'b0, 8'h00);
        check("after_async_y", uo_out, 8'h00);
        check("after_async_flags", uio_out, 8'h40);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
